// File: rtl/hdu_pkg.sv
// Shared definitions for the hazard detection unit and its source decoder.
// Opcode constants, the rt-use helper and the stall counter type live here.
package hdu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int STALL_CNT_W = 2;

    typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

    function automatic logic uses_rt(input logic [5:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: r = 1'b1;
            default:                         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hdu_src_decode.sv
// Source-operand decode of the IF/ID instruction (opcode/rs/rt).
// Shared with the forwarding unit; $0 sources are reported as unused.
module hdu_src_decode
    import hdu_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [5:0]            opcode,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    output logic                  rs_used,
    output logic                  rt_used,
    output logic                  is_branch
);

    logic rs_op;

    assign rs_op = (opcode != OP_J) && (opcode != OP_JAL);

    // $0 is hardwired, so it can never carry a dependency
    assign rs_used = rs_op && (rs != '0);
    assign rt_used = uses_rt(opcode) && (rt != '0);

    assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);

endmodule

// File: rtl/hdu_multicycle.sv
// Multi-cycle hazard detection unit: load-use and branch-in-ID stalls.
// Define HDU_STALL_COUNT_EN to add the stall_cycles_out event counter.
module hdu_multicycle
    import hdu_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_STALL   = 1,
    parameter int BRANCH_IN_ID = 1,
    parameter int CNT_W        = STALL_CNT_W
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  id_ex_memRead_in,
    input  logic                  id_ex_regWrite_in,
    input  logic [REG_ADDR_W-1:0] id_ex_rd_in,
    input  logic                  ex_mem_memRead_in,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd_in,
    input  logic [15:0]           instruction2msb_in,
    output logic                  pc_wr_out,
    output logic                  if_id_wr_out,
    output logic                  flush_control_out,
`ifdef HDU_STALL_COUNT_EN
    output logic [31:0]           stall_cycles_out,
`endif
    output logic                  stall_active_out
);

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] LS_N = CNT_W'(LOAD_STALL);

    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic                  rs_used;
    logic                  rt_used;
    logic                  is_branch;
    logic                  ex_hit;
    logic                  mem_hit;
    logic                  br_chk;
    logic [CNT_W-1:0]      need;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_dec;
    logic [CNT_W-1:0]      need_dec;
    logic [CNT_W-1:0]      cnt_nxt;
    logic                  stall;

    assign opcode = instruction2msb_in[15:10];
    assign rs     = instruction2msb_in[9:5];
    assign rt     = instruction2msb_in[4:0];

    hdu_src_decode #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_dec (
        .opcode    (opcode),
        .rs        (rs),
        .rt        (rt),
        .rs_used   (rs_used),
        .rt_used   (rt_used),
        .is_branch (is_branch)
    );

    assign ex_hit  = (rs_used && rs == id_ex_rd_in)
                  || (rt_used && rt == id_ex_rd_in);
    assign mem_hit = (rs_used && rs == ex_mem_rd_in)
                  || (rt_used && rt == ex_mem_rd_in);
    assign br_chk  = (BRANCH_IN_ID != 0) && is_branch;

    always_comb begin
        need = '0;
        if (id_ex_memRead_in && ex_hit)
            need = LS_N;
        if (br_chk && id_ex_memRead_in && ex_hit && need < TWO)
            need = TWO;
        if (br_chk && need == '0
            && ((id_ex_regWrite_in && !id_ex_memRead_in && ex_hit)
                || (ex_mem_memRead_in && mem_hit)))
            need = ONE;
    end

    // The combinational cycle covers one stall; cnt holds the remainder
    assign cnt_dec  = (cnt != '0) ? cnt - ONE : '0;
    assign need_dec = (need != '0) ? need - ONE : '0;
    assign cnt_nxt  = (need_dec > cnt_dec) ? need_dec : cnt_dec;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end

    assign stall = rst_n_in && ((need != '0) || (cnt != '0));

    assign pc_wr_out         = !stall;
    assign if_id_wr_out      = !stall;
    assign flush_control_out = stall;
    assign stall_active_out  = (cnt != '0);

`ifdef HDU_STALL_COUNT_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            stall_cycles_out <= '0;
        else if (stall)
            stall_cycles_out <= stall_cycles_out + 32'd1;
    end
`endif

endmodule

// File: tb/tb_hdu_multicycle.sv
// Directed testbench for hdu_multicycle (default and LOAD_STALL=3 builds).
// Expected values are hand-computed per vector.
module tb_hdu_multicycle;

    logic        clk;
    logic        rst_n;
    logic        rst3_n;
    logic        id_ex_memRead;
    logic        id_ex_regWrite;
    logic [4:0]  id_ex_rd;
    logic        ex_mem_memRead;
    logic [4:0]  ex_mem_rd;
    logic [15:0] instr;

    logic pc_wr, if_id_wr, flush, active;
    logic pc_wr3, if_id_wr3, flush3, active3;
`ifdef HDU_STALL_COUNT_EN
    logic [31:0] scnt, scnt3;
`endif

    int checks = 0;
    int errors = 0;

    hdu_multicycle u_dut (
        .clk_in             (clk),
        .rst_n_in           (rst_n),
        .id_ex_memRead_in   (id_ex_memRead),
        .id_ex_regWrite_in  (id_ex_regWrite),
        .id_ex_rd_in        (id_ex_rd),
        .ex_mem_memRead_in  (ex_mem_memRead),
        .ex_mem_rd_in       (ex_mem_rd),
        .instruction2msb_in (instr),
        .pc_wr_out          (pc_wr),
        .if_id_wr_out       (if_id_wr),
        .flush_control_out  (flush),
`ifdef HDU_STALL_COUNT_EN
        .stall_cycles_out   (scnt),
`endif
        .stall_active_out   (active)
    );

    hdu_multicycle #(
        .LOAD_STALL (3)
    ) u_dut3 (
        .clk_in             (clk),
        .rst_n_in           (rst3_n),
        .id_ex_memRead_in   (id_ex_memRead),
        .id_ex_regWrite_in  (id_ex_regWrite),
        .id_ex_rd_in        (id_ex_rd),
        .ex_mem_memRead_in  (ex_mem_memRead),
        .ex_mem_rd_in       (ex_mem_rd),
        .instruction2msb_in (instr),
        .pc_wr_out          (pc_wr3),
        .if_id_wr_out       (if_id_wr3),
        .flush_control_out  (flush3),
`ifdef HDU_STALL_COUNT_EN
        .stall_cycles_out   (scnt3),
`endif
        .stall_active_out   (active3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        id_ex_memRead  = 1'b0;
        id_ex_regWrite = 1'b0;
        id_ex_rd       = 5'd0;
        ex_mem_memRead = 1'b0;
        ex_mem_rd      = 5'd0;
        instr          = 16'h0000;
    endtask

    initial begin
        rst_n  = 1'b0;
        rst3_n = 1'b0;
        clr();

        // reset overrides an active hazard (beq $8,$16 after lw $8)
        id_ex_memRead = 1'b1;
        id_ex_rd      = 5'd8;
        instr         = 16'h1110;
        #1;
        chk("rst_pc_wr", pc_wr, 1);
        chk("rst_if_id_wr", if_id_wr, 1);
        chk("rst_flush", flush, 0);
        chk("rst_active", active, 0);
        tick();
        rst_n  = 1'b1;
        rst3_n = 1'b1;
        #1;
        chk("rel_flush", flush, 1);
        chk("rel_pc_wr", pc_wr, 0);
        tick();
        clr();
        #1;
        chk("rel_c2_active", active, 1);
        chk("rel_c2_flush", flush, 1);
        tick();
        #1;
        chk("rel_done_pc_wr", pc_wr, 1);
        chk("rel_done_active", active, 0);
        repeat (3) tick();

        // load-use, add using $8, LOAD_STALL=1
        id_ex_memRead = 1'b1;
        id_ex_rd      = 5'd8;
        instr         = 16'h0109;
        #1;
        chk("lu_pc_wr", pc_wr, 0);
        chk("lu_if_id_wr", if_id_wr, 0);
        chk("lu_flush", flush, 1);
        chk("lu_active", active, 0);
        tick();
        clr();
        #1;
        chk("lu_end_pc_wr", pc_wr, 1);
        chk("lu_end_active", active, 0);
        repeat (3) tick();

        // branch after load: 2 cycles
        id_ex_memRead = 1'b1;
        id_ex_rd      = 5'd16;
        instr         = 16'h1110;
        #1;
        chk("bl_c1_flush", flush, 1);
        chk("bl_c1_active", active, 0);
        tick();
        clr();
        instr          = 16'h1110;
        ex_mem_memRead = 1'b1;
        ex_mem_rd      = 5'd16;
        #1;
        chk("bl_c2_flush", flush, 1);
        chk("bl_c2_active", active, 1);
        tick();
        clr();
        #1;
        chk("bl_c3_pc_wr", pc_wr, 1);
        repeat (3) tick();

        // branch after ALU op: 1 cycle; R-type consumer: none
        id_ex_regWrite = 1'b1;
        id_ex_rd       = 5'd8;
        instr          = 16'h1110;
        #1;
        chk("ba_flush", flush, 1);
        tick();
        instr = 16'h0110;
        #1;
        chk("ba_rtype_flush", flush, 0);
        chk("ba_rtype_active", active, 0);
        tick();
        clr();
        repeat (3) tick();

        // $0 and non-matching destinations
        id_ex_memRead = 1'b1;
        id_ex_rd      = 5'd0;
        instr         = 16'h1000;
        #1;
        chk("z_r0_r0", flush, 0);
        instr = 16'h1110;
        #1;
        chk("z_r0_b", flush, 0);
        id_ex_rd = 5'd30;
        instr    = 16'h1000;
        #1;
        chk("z_r30_r0", flush, 0);
        instr = 16'h1110;
        #1;
        chk("z_r30_b", flush, 0);

        // j ignores rs; sw uses rt; lw does not use rt
        id_ex_rd = 5'd8;
        instr    = 16'h0900;
        #1;
        chk("j_rs", flush, 0);
        id_ex_rd = 5'd9;
        instr    = 16'hAC09;
        #1;
        chk("sw_rt", flush, 1);
        instr = 16'h8C09;
        #1;
        chk("lw_rt", flush, 0);
        tick();
        clr();
        repeat (3) tick();

        // LOAD_STALL=3 aborted by reset mid-stall
        rst3_n = 1'b0;
        #1;
        rst3_n = 1'b1;
        #1;
`ifdef HDU_STALL_COUNT_EN
        chk("ls3_cnt_init", scnt3, 0);
`endif
        id_ex_memRead = 1'b1;
        id_ex_rd      = 5'd8;
        instr         = 16'h0109;
        #1;
        chk("ls3_c1_flush", flush3, 1);
        chk("ls3_c1_active", active3, 0);
        tick();
        clr();
        #1;
        chk("ls3_c2_flush", flush3, 1);
        chk("ls3_c2_active", active3, 1);
        tick();
        #1;
        chk("ls3_c3_flush", flush3, 1);
`ifdef HDU_STALL_COUNT_EN
        chk("ls3_cnt_pre", scnt3, 2);
`endif
        rst3_n = 1'b0;
        #1;
        chk("ls3_rst_pc_wr", pc_wr3, 1);
        chk("ls3_rst_if_id", if_id_wr3, 1);
        chk("ls3_rst_flush", flush3, 0);
        chk("ls3_rst_active", active3, 0);
`ifdef HDU_STALL_COUNT_EN
        chk("ls3_cnt_rst", scnt3, 0);
`endif
        rst3_n = 1'b1;
        #1;
        chk("ls3_post_flush", flush3, 0);
        tick();
        #1;
        chk("ls3_post_pc_wr", pc_wr3, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
